// File: rtl/stim_frame_serializer.sv
// Requests a stimulus word from the generator, packs it into a 40-bit frame and
// shifts it MSB-first on SCLK/SDATA, then strobes SLOAD so the chip latches it.
module stim_frame_serializer #(
  parameter int CLK_DIV   = 4,
  parameter int LOAD_WAIT = 3,
  parameter int GAP_CYC   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        MODE,
  input  logic        BIAS_SEL,
  input  logic [6:0]  BIAS_AMP,
  input  logic [4:0]  ADDR,
  input  logic [7:0]  AMP0,
  input  logic [7:0]  AMP1,
  input  logic [7:0]  AMP2,
  input  logic [7:0]  AMP3,
  output logic        TX_START,
  output logic        SCLK,
  output logic        SDATA,
  output logic        SLOAD,
  output logic        BUSY,
  output logic [15:0] FRAME_CNT
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHIFT, S_LATCH, S_GAP} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] SCLK_HI   = 16'(CLK_DIV);
  localparam logic [15:0] WAIT_LAST = 16'(LOAD_WAIT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [39:0] shreg_q, shreg_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        tx_start_q, tx_start_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        sload_q, sload_d;
  logic        busy_q, busy_d;

  // Bit 0 carries even parity over the whole frame.
  function automatic logic [39:0] pack_frame(
    input logic       mode,
    input logic       bsel,
    input logic [6:0] bamp,
    input logic [4:0] addr,
    input logic [7:0] a0,
    input logic [7:0] a1,
    input logic [7:0] a2,
    input logic [7:0] a3
  );
    logic [39:0] f;
    if (mode) f = {1'b1, addr, a0, a1, a2, a3, 2'b00};
    else      f = {1'b0, bsel, bamp, 31'd0};
    f[0] = ^f[39:1];
    return f;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ENABLE) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          shreg_d = pack_frame(MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3);
        end
      end
      S_SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 6'd39) begin
            state_d     = S_LATCH;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[38:0], 1'b0};
          end
        end
      end
      S_LATCH: begin
        if (cnt_q == BIT_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ENABLE ? S_REQ : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next-state view so they align with the state.
    tx_start_d = (state_d == S_REQ);
    busy_d     = (state_d != S_IDLE);
    sload_d    = (state_d == S_LATCH);
    sclk_d     = (state_d == S_SHIFT) && (cnt_d >= SCLK_HI);
    sdata_d    = (state_d == S_SHIFT) && shreg_d[39];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_cnt_q <= '0;
      tx_start_q  <= 1'b0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sload_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_cnt_q <= frame_cnt_d;
      tx_start_q  <= tx_start_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sload_q     <= sload_d;
      busy_q      <= busy_d;
    end
  end

  assign TX_START  = tx_start_q;
  assign SCLK      = sclk_q;
  assign SDATA     = sdata_q;
  assign SLOAD     = sload_q;
  assign BUSY      = busy_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_stim_frame_serializer.sv
// Directed bench for stim_frame_serializer: frames are rebuilt from SCLK rising
// edges and compared with hand-packed values at default parameters.
module tb_stim_frame_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENABLE = 1'b0;
  logic        MODE = 1'b0;
  logic        BIAS_SEL = 1'b0;
  logic [6:0]  BIAS_AMP = '0;
  logic [4:0]  ADDR = '0;
  logic [7:0]  AMP0 = '0, AMP1 = '0, AMP2 = '0, AMP3 = '0;
  logic        TX_START, SCLK, SDATA, SLOAD, BUSY;
  logic [15:0] FRAME_CNT;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  stim_frame_serializer #(.CLK_DIV(4), .LOAD_WAIT(3), .GAP_CYC(8)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .MODE(MODE), .BIAS_SEL(BIAS_SEL),
    .BIAS_AMP(BIAS_AMP), .ADDR(ADDR), .AMP0(AMP0), .AMP1(AMP1), .AMP2(AMP2),
    .AMP3(AMP3), .TX_START(TX_START), .SCLK(SCLK), .SDATA(SDATA), .SLOAD(SLOAD),
    .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    MODE     = 1'($urandom);
    BIAS_SEL = 1'($urandom);
    BIAS_AMP = 7'($urandom);
    ADDR     = 5'($urandom);
    AMP0     = 8'($urandom);
    AMP1     = 8'($urandom);
    AMP2     = 8'($urandom);
    AMP3     = 8'($urandom);
  endtask

  task automatic set_amp(input logic [4:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    MODE = 1'b1; ADDR = a; AMP0 = b0; AMP1 = b1; AMP2 = b2; AMP3 = b3;
  endtask

  task automatic set_bias(input logic bs, input logic [6:0] ba);
    MODE = 1'b0; BIAS_SEL = bs; BIAS_AMP = ba;
  endtask

  // Waits for the request, rebuilds the frame from SCLK rising edges, then measures SLOAD.
  task automatic run_frame(input string tag, input logic [39:0] exp_frame,
                           input logic [15:0] exp_cnt, input int drop_at, output int t_start);
    int n;
    int rises;
    int viol;
    logic [39:0] got;
    logic prev_sclk, prev_sdata;
    n = 0;
    while (TX_START !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    chk({tag, "_req"}, 40'(TX_START), 40'd1);
    t_start = cyc;
    got = '0; rises = 0; viol = 0; n = 0;
    prev_sclk = SCLK; prev_sdata = SDATA;
    while (rises < 40 && n < 1000) begin
      @(negedge CLK); n++;
      if (SCLK && prev_sclk && (SDATA !== prev_sdata)) viol++;
      if (SCLK && !prev_sclk) begin
        got = {got[38:0], SDATA};
        rises++;
        if (rises == 1) scramble();
        if (rises == drop_at) ENABLE = 1'b0;
      end
      prev_sclk = SCLK; prev_sdata = SDATA;
    end
    chk({tag, "_frame"}, got, exp_frame);
    chk({tag, "_sdata_stable"}, 40'(viol), 40'd0);
    n = 0;
    while (SLOAD !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    chk({tag, "_frame_cnt"}, 40'(FRAME_CNT), 40'(exp_cnt));
    n = 0;
    while (SLOAD === 1'b1 && n < 100) begin n++; @(negedge CLK); end
    chk({tag, "_sload_len"}, 40'(n), 40'd8);
  endtask

  initial begin
    int ta, tb_, tc, td, n, seen;

    // Reset held with ENABLE high
    RST = 1'b0; ENABLE = 1'b1;
    set_amp(5'd5, 8'd0, 8'd25, 8'd0, 8'd0);
    repeat (5) @(negedge CLK);
    chk("rst_tx_start", 40'(TX_START), 40'd0);
    chk("rst_sclk", 40'(SCLK), 40'd0);
    chk("rst_sdata", 40'(SDATA), 40'd0);
    chk("rst_sload", 40'(SLOAD), 40'd0);
    chk("rst_busy", 40'(BUSY), 40'd0);
    chk("rst_frame_cnt", 40'(FRAME_CNT), 40'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_tx_start", 40'(TX_START), 40'd1);
    chk("post_rst_busy", 40'(BUSY), 40'd1);

    // Amplitude word, then two bias words with ENABLE held
    run_frame("amp_a", 40'h94_0064_0000, 16'd1, -1, ta);
    set_bias(1'b0, 7'd57);
    run_frame("bias57", 40'h1C_8000_0000, 16'd2, -1, tb_);
    chk("period_1", 40'(tb_ - ta), 40'd340);
    set_bias(1'b0, 7'd1);
    run_frame("bias1", 40'h00_8000_0001, 16'd3, -1, tc);
    chk("period_2", 40'(tc - tb_), 40'd340);

    // ENABLE dropped at bit 10: frame completes, then idle
    set_bias(1'b1, 7'd127);
    run_frame("drop", 40'h7F_8000_0000, 16'd4, 10, td);
    chk("drop_period", 40'(td - tc), 40'd340);
    n = 0;
    while (BUSY === 1'b1 && n < 50) begin n++; @(negedge CLK); end
    chk("drop_gap_len", 40'(n), 40'd8);
    seen = 0;
    repeat (400) begin
      @(negedge CLK);
      if (TX_START === 1'b1) seen++;
    end
    chk("drop_no_tx", 40'(seen), 40'd0);
    chk("drop_busy_idle", 40'(BUSY), 40'd0);
    chk("drop_frame_cnt", 40'(FRAME_CNT), 40'd4);

    // Reset in the middle of bit 20
    set_amp(5'd31, 8'hA5, 8'h3C, 8'h81, 8'hFF);
    ENABLE = 1'b1;
    n = 0;
    while (TX_START !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    chk("mid_req", 40'(TX_START), 40'd1);
    seen = 0; n = 0;
    begin
      logic prev;
      prev = SCLK;
      while (seen < 20 && n < 1000) begin
        @(negedge CLK); n++;
        if (SCLK && !prev) seen++;
        prev = SCLK;
      end
    end
    chk("mid_reached_bit20", 40'(seen), 40'd20);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_sclk", 40'(SCLK), 40'd0);
    chk("mid_rst_sdata", 40'(SDATA), 40'd0);
    chk("mid_rst_sload", 40'(SLOAD), 40'd0);
    chk("mid_rst_busy", 40'(BUSY), 40'd0);
    chk("mid_rst_tx_start", 40'(TX_START), 40'd0);
    chk("mid_rst_frame_cnt", 40'(FRAME_CNT), 40'd0);
    RST = 1'b1;

    // Full frame after the abort starts from a clean state
    run_frame("after_rst", 40'hFE_94F2_07FC, 16'd1, -1, ta);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
